jmr_fetch_sequencer: RTL and testbench

Fetch/execute sequencer and program counter that feeds the JMR jump decoder. It fetches each 16-bit instruction from instruction memory over a request/acknowledge handshake and holds it in an instruction register (IR). The IR drives the decoder's `INSTR` input. In the execute state the sequencer samples the decoder's `JUMP` result and selects the next PC: either the relative jump target or PC+1.

---
 rtl/jmr_pkg.sv | 58 +++++
 rtl/jmr_fetch_sequencer_if.sv | 30 +++
 rtl/jmr_pc_next.sv | 26 ++
 rtl/jmr_fetch_sequencer.sv | 81 ++++++++
 tb/tb_jmr_fetch_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jmr_pkg.sv
// Purpose: shared types and constants for the JMR fetch sequencer.
//   - state encoding (FETCH/DECODE/EXEC, visible on STATE for debug)
//   - instruction field layout and JMR opcode default
//   - condition-code encoding used by the downstream jump decoder
//   - helper that sign-extends the 4-bit relative jump offset
package jmr_pkg;

  localparam int unsigned XLEN    = 16;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned COND_W  = 3;
  localparam int unsigned X_W     = 4;
  localparam int unsigned OFF_W   = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [OPC_W-1:0] JMR_OPCODE_DEFAULT = 5'b11000;

  // Instruction field slices.
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 11;
  localparam int unsigned COND_MSB = 10;
  localparam int unsigned COND_LSB = 8;
  localparam int unsigned X_MSB    = 7;
  localparam int unsigned X_LSB    = 4;
  localparam int unsigned OFF_MSB  = 3;
  localparam int unsigned OFF_LSB  = 0;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  // Condition codes evaluated by the JMR decoder.
  typedef enum logic [COND_W-1:0] {
    COND_ZERO    = 3'd0,
    COND_NONZERO = 3'd1,
    COND_EQ      = 3'd2,
    COND_NE      = 3'd3,
    COND_LT      = 3'd4,
    COND_LE      = 3'd5,
    COND_BIT     = 3'd6,
    COND_CARRY   = 3'd7
  } cond_t;

  // Instruction word layout; field order matches the slice constants above.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    cond_t            cond;
    logic [X_W-1:0]   x;
    logic [OFF_W-1:0] offset;
  } instr_t;

  // Sign-extend the relative jump offset to PC width (range -8..+7).
  function automatic logic [XLEN-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(XLEN-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/jmr_fetch_sequencer_if.sv
// Purpose: bundle of the sequencer's memory handshake and decoder/datapath
// signals.
//   master : the sequencer (drives fetch request, IR, PC, debug state)
//   slave  : memory / decoder / datapath side
interface jmr_fetch_sequencer_if;
  import jmr_pkg::*;

  logic               IMEM_REQ;
  logic [XLEN-1:0]    IMEM_ADDR;
  logic [XLEN-1:0]    IMEM_RDATA;
  logic               IMEM_ACK;
  logic [XLEN-1:0]    INSTR;
  logic               JUMP;
  logic               EXEC_DONE;
  logic               STALL;
  logic [XLEN-1:0]    PC;
  logic               IS_JMR;
  logic [STATE_W-1:0] STATE;

  modport master (
    output IMEM_REQ, IMEM_ADDR, INSTR, PC, IS_JMR, STATE,
    input  IMEM_RDATA, IMEM_ACK, JUMP, EXEC_DONE, STALL
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, INSTR, PC, IS_JMR, STATE,
    output IMEM_RDATA, IMEM_ACK, JUMP, EXEC_DONE, STALL
  );

endinterface

// File: rtl/jmr_pc_next.sv
// Purpose: next-PC computation (combinational).
//   pc        : current program counter
//   offset    : IR[3:0], signed relative jump offset
//   take      : 1 = take relative jump, 0 = sequential PC+1
//   next_pc_c : resulting PC, modulo 2^16
module jmr_pc_next
  import jmr_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             take,
  output logic [XLEN-1:0]  next_pc_c
);

  logic [XLEN-1:0] step;

  // Jump target is relative to the JMR instruction's own address.
  always_comb begin
    step = XLEN'(1);
    if (take) begin
      step = sext_offset(offset);
    end
    next_pc_c = pc + step;
  end

endmodule

// File: rtl/jmr_fetch_sequencer.sv
// Purpose: fetch/decode/execute sequencer and program counter feeding the
// JMR jump decoder.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : master side of jmr_fetch_sequencer_if
//     IMEM_REQ/IMEM_ADDR/IMEM_RDATA/IMEM_ACK : instruction fetch handshake
//     INSTR/IS_JMR/JUMP                      : IR to decoder, decoder result
//     EXEC_DONE/STALL                        : datapath completion and hold
//     PC/STATE                               : program counter, debug state
// All outputs come straight from registers (or a decode of registers).
module jmr_fetch_sequencer
  import jmr_pkg::*;
#(
  parameter logic [XLEN-1:0]  RESET_PC   = 16'h0000,
  parameter logic [OPC_W-1:0] JMR_OPCODE = JMR_OPCODE_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  jmr_fetch_sequencer_if.master bus
);

  state_t          state;
  logic [XLEN-1:0] pc;
  instr_t          ir;
  logic            is_jmr;
  logic            take;
  logic [XLEN-1:0] next_pc;

  assign is_jmr = (ir.opcode == JMR_OPCODE);
  // JUMP only matters for a JMR; it is sampled solely at the EXEC exit edge.
  assign take   = is_jmr & bus.JUMP;

  jmr_pc_next u_pc_next (
    .pc        (pc),
    .offset    (ir.offset),
    .take      (take),
    .next_pc_c (next_pc)
  );

  // Sequencer state, PC and IR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        FETCH: begin
          // STALL has no effect here: a started fetch always completes.
          if (bus.IMEM_ACK) begin
            ir    <= instr_t'(bus.IMEM_RDATA);
            state <= DECODE;
          end
        end
        DECODE: begin
          // One full cycle for the decoder and register read to settle.
          if (!bus.STALL) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          // STALL overrides EXEC_DONE; a JMR never waits for EXEC_DONE.
          if (!bus.STALL && (is_jmr || bus.EXEC_DONE)) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign bus.IMEM_REQ  = (state == FETCH);
  assign bus.IMEM_ADDR = pc;
  assign bus.INSTR     = ir;
  assign bus.PC        = pc;
  assign bus.IS_JMR    = is_jmr;
  assign bus.STATE     = STATE_W'(state);

endmodule

// File: tb/tb_jmr_fetch_sequencer.sv
// Purpose: self-checking bench for jmr_fetch_sequencer. A per-instruction
// reference model tracks the program counter with plain integer arithmetic
// and predicts the cycle-by-cycle handshake/state behaviour.
module tb_jmr_fetch_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   m_pc;

  jmr_fetch_sequencer_if bus ();

  jmr_fetch_sequencer dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_is_jmr(input logic [15:0] w);
    return int'(w >> 11) == 24;
  endfunction

  // Next PC from the architectural rule: jump by signed offset or step by one.
  function automatic int model_next(input int pc, input logic [15:0] w, input bit jump);
    int off;
    off = int'(w & 16'h000F);
    if (off > 7) off = off - 16;
    if (model_is_jmr(w) && jump) return (pc + off + 65536) % 65536;
    return (pc + 1) % 65536;
  endfunction

  // Full instruction: fetch with wait states, optional DECODE/EXEC stalls,
  // then EXEC exit. Stray ACKs with junk data are offered outside FETCH.
  task automatic run_instr(input logic [15:0] word, input int waits,
                           input int dstall, input int estall,
                           input bit jump, input int done_delay);
    bit jmr;
    int nxt;
    jmr = model_is_jmr(word);
    nxt = model_next(m_pc, word, jump);

    bus.IMEM_ACK = 1'b0;
    for (int i = 0; i < waits; i++) begin
      bus.IMEM_RDATA = 16'($urandom);
      check("fetch_wait_state", 16'(bus.STATE), 16'd0);
      check("fetch_wait_req", 16'(bus.IMEM_REQ), 16'd1);
      check("fetch_wait_addr", bus.IMEM_ADDR, 16'(m_pc));
      tick();
    end
    check("fetch_req", 16'(bus.IMEM_REQ), 16'd1);
    check("fetch_addr", bus.IMEM_ADDR, 16'(m_pc));
    bus.IMEM_ACK   = 1'b1;
    bus.IMEM_RDATA = word;
    tick();

    check("decode_state", 16'(bus.STATE), 16'd1);
    check("decode_instr", bus.INSTR, word);
    check("decode_is_jmr", 16'(bus.IS_JMR), 16'(jmr));
    check("decode_req", 16'(bus.IMEM_REQ), 16'd0);
    bus.EXEC_DONE = 1'b1;
    for (int i = 0; i < dstall; i++) begin
      bus.STALL      = 1'b1;
      bus.JUMP       = ~bus.JUMP;
      bus.IMEM_RDATA = 16'($urandom);
      tick();
      check("decode_stall_state", 16'(bus.STATE), 16'd1);
      check("decode_stall_instr", bus.INSTR, word);
    end
    bus.STALL      = 1'b0;
    bus.IMEM_RDATA = 16'($urandom);
    tick();

    check("exec_state", 16'(bus.STATE), 16'd2);
    check("exec_pc", bus.PC, 16'(m_pc));
    for (int i = 0; i < estall; i++) begin
      bus.STALL      = 1'b1;
      bus.EXEC_DONE  = 1'b1;
      bus.JUMP       = ~bus.JUMP;
      bus.IMEM_RDATA = 16'($urandom);
      tick();
      check("exec_stall_state", 16'(bus.STATE), 16'd2);
      check("exec_stall_pc", bus.PC, 16'(m_pc));
      check("exec_stray_ack_instr", bus.INSTR, word);
    end
    bus.STALL = 1'b0;
    if (jmr) begin
      bus.EXEC_DONE = 1'($urandom);
      bus.JUMP      = jump;
      tick();
    end else begin
      for (int i = 0; i < done_delay; i++) begin
        bus.EXEC_DONE = 1'b0;
        bus.JUMP      = 1'($urandom);
        tick();
        check("exec_wait_done_state", 16'(bus.STATE), 16'd2);
        check("exec_wait_done_pc", bus.PC, 16'(m_pc));
      end
      bus.EXEC_DONE = 1'b1;
      bus.JUMP      = 1'b1;
      tick();
    end
    m_pc = nxt;
    bus.IMEM_ACK  = 1'b0;
    bus.EXEC_DONE = 1'b1;
    check("exit_state", 16'(bus.STATE), 16'd0);
    check("exit_pc", bus.PC, 16'(m_pc));
    check("exit_addr", bus.IMEM_ADDR, 16'(m_pc));
    check("exit_instr_kept", bus.INSTR, word);
  endtask

  function automatic logic [15:0] jmr_word(input logic [3:0] off);
    return {5'b11000, 3'($urandom), 4'($urandom), off};
  endfunction

  function automatic logic [15:0] rand_non_jmr();
    logic [15:0] w;
    w = 16'($urandom);
    while (w[15:11] == 5'b11000) w = 16'($urandom);
    return w;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, bus.PC, 16'h0000);
    check({tag, "_state"}, 16'(bus.STATE), 16'd0);
    check({tag, "_req"}, 16'(bus.IMEM_REQ), 16'd1);
    check({tag, "_addr"}, bus.IMEM_ADDR, 16'h0000);
    check({tag, "_instr"}, bus.INSTR, 16'h0000);
    check({tag, "_is_jmr"}, 16'(bus.IS_JMR), 16'd0);
  endtask

  initial begin
    logic [15:0] w;
    n_tests = 0;
    n_fail  = 0;
    m_pc    = 0;
    rst            = 1'b1;
    bus.IMEM_ACK   = 1'b0;
    bus.IMEM_RDATA = 16'h0000;
    bus.JUMP       = 1'b0;
    bus.EXEC_DONE  = 1'b1;
    bus.STALL      = 1'b0;

    // Reset state.
    #3;
    check_reset_values("reset");
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("after_release");

    // Sequential non-JMR, zero-wait: PC 0 -> 1 -> 2 -> 3, 3 cycles each.
    for (int i = 0; i < 3; i++) run_instr(16'h0000, 0, 0, 0, 1'b0, 0);

    // 3 -> 0x0A -> 0x10, then JMR +5 not taken / back / taken.
    run_instr(jmr_word(4'h7), 0, 0, 0, 1'b1, 0);
    run_instr(jmr_word(4'h6), 0, 0, 0, 1'b1, 0);
    check("at_0x10", bus.IMEM_ADDR, 16'h0010);
    run_instr(jmr_word(4'h5), 0, 0, 0, 1'b0, 0);
    check("jmr_not_taken", bus.IMEM_ADDR, 16'h0011);
    run_instr(jmr_word(4'hF), 0, 0, 0, 1'b1, 0);
    run_instr(jmr_word(4'h5), 0, 0, 0, 1'b1, 0);
    check("jmr_taken_plus5", bus.IMEM_ADDR, 16'h0015);

    // 0x15 -> 0x0D -> 0x05 -> 0x02, then offset 0xC -> 0xFFFE.
    run_instr(jmr_word(4'h8), 0, 0, 0, 1'b1, 0);
    run_instr(jmr_word(4'h8), 0, 0, 0, 1'b1, 0);
    run_instr(jmr_word(4'hD), 0, 0, 0, 1'b1, 0);
    check("at_0x02", bus.IMEM_ADDR, 16'h0002);
    run_instr(jmr_word(4'hC), 0, 0, 0, 1'b1, 0);
    check("jmr_negative_wrap", bus.PC, 16'hFFFE);
    run_instr(rand_non_jmr(), 0, 0, 0, 1'b0, 0);
    run_instr(rand_non_jmr(), 0, 0, 0, 1'b0, 1);
    check("pc_wrap_to_zero", bus.PC, 16'h0000);

    // Offset 0 taken: tight loop on the same address.
    run_instr(jmr_word(4'h0), 0, 0, 0, 1'b1, 0);
    check("offset0_loop", bus.IMEM_ADDR, 16'h0000);
    run_instr(jmr_word(4'h7), 0, 0, 0, 1'b1, 0);

    // ACK delayed 4 cycles; 3-cycle stalls in DECODE and EXEC with
    // EXEC_DONE high and JUMP toggling.
    run_instr(rand_non_jmr(), 4, 3, 3, 1'b0, 0);
    run_instr(jmr_word(4'h3), 4, 3, 3, 1'b1, 0);
    run_instr(jmr_word(4'h3), 1, 3, 3, 1'b0, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) w = jmr_word(4'($urandom));
      else w = rand_non_jmr();
      run_instr(w, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                int'($urandom_range(2, 0)), 1'($urandom),
                int'($urandom_range(2, 0)));
    end
    if (m_pc == 0) run_instr(rand_non_jmr(), 0, 0, 0, 1'b0, 0);

    // Reset mid-FETCH with an ACK in flight.
    bus.IMEM_ACK = 1'b0;
    tick();
    tick();
    bus.IMEM_ACK   = 1'b1;
    bus.IMEM_RDATA = jmr_word(4'h4);
    rst = 1'b1;
    #2;
    check_reset_values("reset_mid_fetch");
    tick();
    check_reset_values("reset_mid_fetch_held");
    bus.IMEM_ACK = 1'b0;
    rst = 1'b0;
    m_pc = 0;
    tick();
    run_instr(rand_non_jmr(), 1, 0, 0, 1'b0, 0);
    run_instr(jmr_word(4'h6), 0, 0, 0, 1'b1, 0);

    // Reset mid-EXEC.
    bus.IMEM_ACK   = 1'b1;
    bus.IMEM_RDATA = jmr_word(4'h2);
    tick();
    bus.STALL = 1'b0;
    tick();
    check("pre_reset_exec_state", 16'(bus.STATE), 16'd2);
    bus.STALL = 1'b1;
    rst = 1'b1;
    #2;
    check_reset_values("reset_mid_exec");
    tick();
    bus.IMEM_ACK = 1'b0;
    bus.STALL    = 1'b0;
    rst = 1'b0;
    m_pc = 0;
    tick();
    run_instr(jmr_word(4'h1), 0, 0, 0, 1'b1, 0);
    run_instr(rand_non_jmr(), 2, 1, 1, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
